mbist_mem_arbiter: RTL and testbench
====================================

Name: mbist_mem_arbiter

Overview:
- Owns the single dual-port memory (separate write and read ports) and shares it between two functional requesters and the BIST controller.
- In functional mode it round-robins one access per cycle between requesters 0 and 1 and returns read data to whichever requester issued the read.
- When Test rises it stops granting, drains in-flight reads, hands the memory ports to the BIST controller and enables BIST. When Test falls it returns the memory to functional use.

Parameters:
- DWIDTH, 32, data width of the memory and all data ports.
- AWIDTH, 4, address width of the memory and all address ports.

Ports:
- clk  in  1  single clock; everything is sampled on posedge.
- rst  in  1  asynchronous reset, active-high.
- Test  in  1  BIST mode request.
- req0, req1  in  1  functional access request; held until granted.
- wr0, wr1  in  1  1 = write, 0 = read; qualifies reqN.
- addr0, addr1  in  AWIDTH  access address.
- wdata0, wdata1  in  DWIDTH  write data.
- gnt0, gnt1  out  1  combinational accept; the request is consumed at the edge where gntN=1.
- rvalid0, rvalid1  out  1  read data valid for requester N.
- rdata0, rdata1  out  DWIDTH  read data; equals mem_rdata while rvalidN=1, else 0.
- bist_we, bist_re  in  1  BIST memory strobes.
- bist_wraddr, bist_rdaddr  in  AWIDTH  BIST addresses.
- bist_datain  in  DWIDTH  BIST write data.
- bist_go  out  1  Test input for bist_controller; high only in state TEST.
- we, re  out  1  memory write and read strobes.
- wraddr, rdaddr  out  AWIDTH  memory addresses.
- datain  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data; valid the cycle after re is sampled.
- busy  out  1  high in every state except FUNC.

Behaviour:
- Reset state: FUNC. All outputs are 0 during and after reset, the round-robin pointer selects requester 0 first, and the read pipeline is empty.
- States: FUNC, DRAIN, TEST, RELEASE, encoded 2 bits.
- FUNC:
  - At most one grant per cycle.
  - If only one requester is asserting, it is granted.
  - If both are asserting, the requester not granted most recently wins, and the pointer updates on every grant.
  - On the granted edge, memory outputs are registered for exactly one cycle:
    - write: we=1, wraddr=addrN, datain=wdataN.
    - read: re=1, rdaddr=addrN.
  - Ungranted cycles drive we=re=0. Addresses and data hold their last value.
- Read latency: request granted in cycle C, re=1 in C+1, rvalidN=1 in C+2 with rdataN=mem_rdata. A 2-stage owner/valid shift register tracks up to 2 reads in flight.
- Write latency: we=1 in C+1; no response is returned to the requester.
- FUNC to DRAIN: taken when Test=1 is sampled. gnt0=gnt1=0 in the same cycle that Test=1.
- DRAIN: no grants. Any in-flight rvalid still completes. Once the pipeline is empty:
  - Test=1: go to TEST.
  - Test=0: go back to FUNC.
- TEST:
  - we, re, wraddr, rdaddr and datain are registered copies of the bist_* inputs, giving one cycle of added latency.
  - bist_go=1.
  - gnt0, gnt1, rvalid0 and rvalid1 are all 0.
  - When Test=0 is sampled, go to RELEASE.
- RELEASE: one cycle with we=re=0 and bist_go=0, then FUNC. The round-robin pointer is preserved across test mode.
- Reset asserted mid-operation, in any state: return to FUNC immediately. In-flight reads are discarded and no rvalid is produced.
- A requester may switch wrN/addrN only after its gnt or while its req is low. Behaviour is otherwise undefined.

Optional Feature:
- Macro MBIST_ARB_STATS_EN.
- When defined, adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each:
  - per-requester grant counters;
  - saturate at 0xFFFF;
  - cleared by rst;
  - not cleared by Test.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5A5A5A5 -> gnt0 comb in C; we=1, wraddr=3, datain=0xA5A5A5A5 in C+1.
- req0 read addr 3 after that write -> re=1, rdaddr=3 in C+1; rvalid0=1 and rdata0=0xA5A5A5A5 in C+2; rvalid1 stays 0.
- req0 and req1 held continuously, both reads -> grants alternate 0,1,0,1; rvalid alternates two cycles behind the grants.
- Read granted in C, Test=1 in C+1 -> no grants from C+1; rvalid arrives in C+2; busy=1; bist_go=1 once the pipeline is empty; full BIST pass then bist_check_valid with bist_status=0.
- Test drops in TEST -> RELEASE for one cycle with we=re=0; FUNC next cycle; the pending req1 is granted first if requester 0 was granted last.
- rst pulsed mid-read and mid-TEST -> all outputs 0 immediately, no stray rvalid. With MBIST_ARB_STATS_EN, 5 grants to requester 0 give gnt_cnt0=5, and rst clears it to 0.

Source files
------------

// File: rtl/mbist_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mbist_mem_arbiter
//
// Owns one dual-port memory (separate write and read ports) and shares it
// between two functional requesters and the BIST controller.
//
// Functional mode (FUNC):
//   One access per cycle, round-robin between requesters 0 and 1. A granted
//   access is registered onto the memory ports for exactly one cycle. A read
//   returns its data to the requester that issued it, two cycles after the
//   grant.
//
// Test mode:
//   When Test rises, granting stops and in-flight reads drain (DRAIN). Then
//   the memory ports are driven from registered copies of the bist_* inputs
//   and bist_go is raised (TEST). When Test falls, one quiet cycle (RELEASE)
//   precedes the return to FUNC.
//
// Handshake: reqN/wrN/addrN/wdataN form a valid, gntN is a combinational
// ready; the access is consumed at the clock edge where reqN && gntN are
// both high. The requester must hold its request stable until then. There
// is no backpressure on the read response: rvalidN is high for one cycle
// and rdataN must be taken in that cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Test                BIST mode request
//   req/wr/addr/wdataN  functional requests (N = 0, 1)
//   gntN                combinational accept
//   rvalidN, rdataN     read response (rdataN is 0 unless rvalidN)
//   bist_*              BIST memory strobes, addresses and write data
//   bist_go             high only in TEST
//   we, re, wraddr, rdaddr, datain   registered memory port drives
//   mem_rdata           memory read data, valid the cycle after re
//   busy                high in every state except FUNC
//   dbg_state           current FSM state (FUNC=0 DRAIN=1 TEST=2 RELEASE=3)
//
// Optional feature: define MBIST_ARB_STATS_EN to add gnt_cnt0/gnt_cnt1,
// 16-bit saturating per-requester grant counters cleared only by rst.
// ---------------------------------------------------------------------------
module mbist_mem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Test,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  input  logic              bist_we,
  input  logic              bist_re,
  input  logic [AWIDTH-1:0] bist_wraddr,
  input  logic [AWIDTH-1:0] bist_rdaddr,
  input  logic [DWIDTH-1:0] bist_datain,
  output logic              bist_go,
  output logic              we,
  output logic              re,
  output logic [AWIDTH-1:0] wraddr,
  output logic [AWIDTH-1:0] rdaddr,
  output logic [DWIDTH-1:0] datain,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
`ifdef MBIST_ARB_STATS_EN
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    FUNC    = 2'd0,
    DRAIN   = 2'd1,
    TEST    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // prio1_q = 1 means requester 1 wins a tie (requester 0 was granted last).
  logic prio1_q;

  // Read-response pipeline: stage 1 is the cycle re is on the memory port,
  // stage 2 is the cycle mem_rdata is valid and returned.
  logic s1_v;
  logic s1_own;
  logic s2_v;
  logic s2_own;
  logic pipe_empty;

  logic grant_ok;

  // Grants are suppressed in the very cycle Test is seen, and while rst is
  // high so that every output reads 0 during reset.
  assign grant_ok   = (state_q == FUNC) && !Test && !rst;
  assign gnt0       = grant_ok && req0 && (!req1 || !prio1_q);
  assign gnt1       = grant_ok && req1 && (!req0 ||  prio1_q);
  assign pipe_empty = !s1_v && !s2_v;

  assign rvalid0   = s2_v && !s2_own;
  assign rvalid1   = s2_v &&  s2_own;
  assign rdata0    = rvalid0 ? mem_rdata : '0;
  assign rdata1    = rvalid1 ? mem_rdata : '0;
  assign bist_go   = (state_q == TEST);
  assign busy      = (state_q != FUNC);
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FUNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FUNC:    if (Test) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = Test ? TEST : FUNC;
      TEST:    if (!Test) state_d = RELEASE;
      RELEASE: state_d = FUNC;
      default: state_d = FUNC;
    endcase
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer; untouched outside FUNC so it survives test mode.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio1_q <= 1'b0;
    end else if (gnt0) begin
      prio1_q <= 1'b1;
    end else if (gnt1) begin
      prio1_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Read owner/valid shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_own <= 1'b0;
      s2_v   <= 1'b0;
      s2_own <= 1'b0;
    end else begin
      s1_v   <= (gnt0 && !wr0) || (gnt1 && !wr1);
      s1_own <= gnt1;
      s2_v   <= s1_v;
      s2_own <= s1_own;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port registers. In TEST the bist_* inputs are copied each cycle;
  // on the edge that leaves TEST the strobes are forced low so RELEASE is
  // quiet. Addresses and data hold whenever nothing new is issued.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we     <= 1'b0;
      re     <= 1'b0;
      wraddr <= '0;
      rdaddr <= '0;
      datain <= '0;
    end else if (state_q == TEST && Test) begin
      we     <= bist_we;
      re     <= bist_re;
      wraddr <= bist_wraddr;
      rdaddr <= bist_rdaddr;
      datain <= bist_datain;
    end else if (gnt0) begin
      we <= wr0;
      re <= !wr0;
      if (wr0) begin
        wraddr <= addr0;
        datain <= wdata0;
      end else begin
        rdaddr <= addr0;
      end
    end else if (gnt1) begin
      we <= wr1;
      re <= !wr1;
      if (wr1) begin
        wraddr <= addr1;
        datain <= wdata1;
      end else begin
        rdaddr <= addr1;
      end
    end else begin
      we <= 1'b0;
      re <= 1'b0;
    end
  end

`ifdef MBIST_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating grant counters; only rst clears them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mbist_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mbist_mem_arbiter
//
// Directed bench for mbist_mem_arbiter with a behavioural dual-port memory
// attached to the memory ports. Inputs change 1 time unit after posedge;
// outputs are observed 2 time units after posedge.
// ---------------------------------------------------------------------------
module tb_mbist_mem_arbiter;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 4;

  logic              clk;
  logic              rst;
  logic              Test;
  logic              req0, req1, wr0, wr1;
  logic [AWIDTH-1:0] addr0, addr1;
  logic [DWIDTH-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DWIDTH-1:0] rdata0, rdata1;
  logic              bist_we, bist_re;
  logic [AWIDTH-1:0] bist_wraddr, bist_rdaddr;
  logic [DWIDTH-1:0] bist_datain;
  logic              bist_go, we, re, busy;
  logic [AWIDTH-1:0] wraddr, rdaddr;
  logic [DWIDTH-1:0] datain;
  logic [DWIDTH-1:0] mem_rdata;
  logic [1:0]        dbg_state;
`ifdef MBIST_ARB_STATS_EN
  logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  mbist_mem_arbiter #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst), .Test(Test),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .bist_we(bist_we), .bist_re(bist_re),
    .bist_wraddr(bist_wraddr), .bist_rdaddr(bist_rdaddr),
    .bist_datain(bist_datain), .bist_go(bist_go),
    .we(we), .re(re), .wraddr(wraddr), .rdaddr(rdaddr), .datain(datain),
    .mem_rdata(mem_rdata), .busy(busy),
`ifdef MBIST_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
  always @(posedge clk) begin
    if (we) mem[wraddr] <= datain;
    if (re) mem_rdata <= mem[rdaddr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bist_we = 0; bist_re = 0; bist_wraddr = '0; bist_rdaddr = '0;
    bist_datain = '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    idle_inputs();
    Test = 0;
    rst = 1;
    req0 = 1; req1 = 1;
    #2;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL reset_gnt: got %b%b exp 00", gnt0, gnt1); end
    checks++; if (we !== 1'b0 || re !== 1'b0 || wraddr !== 4'd0 || datain !== 32'd0) begin errors++;
      $display("FAIL reset_mem: got we=%b re=%b wraddr=%h datain=%h exp all 0", we, re, wraddr, datain); end
    checks++; if (busy !== 1'b0 || bist_go !== 1'b0 || rvalid0 !== 1'b0 || rdata0 !== 32'd0) begin errors++;
      $display("FAIL reset_status: got busy=%b bist_go=%b rvalid0=%b rdata0=%h exp 0", busy, bist_go, rvalid0, rdata0); end
    tick(); tick();
    rst = 0; req0 = 0; req1 = 0;
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++;
      $display("FAIL reset_state: got %0d exp 0", dbg_state); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write;
    tick();
    req0 = 1; wr0 = 1; addr0 = 4'd3; wdata0 = 32'hA5A5A5A5;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL write_gnt: got %b%b exp 10", gnt0, gnt1); end
    checks++; if (we !== 1'b0) begin errors++;
      $display("FAIL write_we_early: got %b exp 0", we); end
    tick();
    req0 = 0; wr0 = 0;
    #1;
    checks++; if (we !== 1'b1 || re !== 1'b0 || wraddr !== 4'd3 || datain !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL write_port: got we=%b re=%b wraddr=%h datain=%h exp 1 0 3 a5a5a5a5", we, re, wraddr, datain); end
    tick();
    #1;
    checks++; if (we !== 1'b0 || wraddr !== 4'd3) begin errors++;
      $display("FAIL write_one_cycle: got we=%b wraddr=%h exp 0 3", we, wraddr); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_read;
    req0 = 1; wr0 = 0; addr0 = 4'd3;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++;
      $display("FAIL read_gnt: got %b exp 1", gnt0); end
    tick();
    req0 = 0;
    #1;
    checks++; if (re !== 1'b1 || rdaddr !== 4'd3 || we !== 1'b0 || rvalid0 !== 1'b0) begin errors++;
      $display("FAIL read_port: got re=%b rdaddr=%h we=%b rvalid0=%b exp 1 3 0 0", re, rdaddr, we, rvalid0); end
    tick();
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5 || rvalid1 !== 1'b0 || rdata1 !== 32'd0) begin errors++;
      $display("FAIL read_resp: got rvalid0=%b rdata0=%h rvalid1=%b rdata1=%h exp 1 a5a5a5a5 0 0", rvalid0, rdata0, rvalid1, rdata1); end
    tick();
    #1;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'd0 || re !== 1'b0) begin errors++;
      $display("FAIL read_done: got rvalid0=%b rdata0=%h re=%b exp 0 0 0", rvalid0, rdata0, re); end
  endtask

  // -------------------------------------------------------------------------
  // Requester 0 was granted last, so a lone requester 1 write is taken, then
  // both held reads alternate starting with requester 0.
  task automatic test_back_to_back;
    logic e_g0, e_g1, e_v0, e_v1;
    req1 = 1; wr1 = 1; addr1 = 4'd7; wdata1 = 32'h12345678;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++;
      $display("FAIL b2b_wr1_gnt: got %b%b exp 01", gnt0, gnt1); end
    tick();
    req1 = 0; wr1 = 0;
    tick();
    req0 = 1; wr0 = 0; addr0 = 4'd3;
    req1 = 1; wr1 = 0; addr1 = 4'd7;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin req0 = 0; req1 = 0; end
      #1;
      e_g0 = (i < 4) && (i % 2 == 0);
      e_g1 = (i < 4) && (i % 2 == 1);
      e_v0 = (i >= 2) && (i % 2 == 0);
      e_v1 = (i >= 2) && (i % 2 == 1);
      checks++; if (gnt0 !== e_g0 || gnt1 !== e_g1) begin errors++;
        $display("FAIL b2b_gnt[%0d]: got %b%b exp %b%b", i, gnt0, gnt1, e_g0, e_g1); end
      checks++; if (rvalid0 !== e_v0 || rvalid1 !== e_v1) begin errors++;
        $display("FAIL b2b_rvalid[%0d]: got %b%b exp %b%b", i, rvalid0, rvalid1, e_v0, e_v1); end
      if (e_v0) begin
        checks++; if (rdata0 !== 32'hA5A5A5A5) begin errors++;
          $display("FAIL b2b_rdata0[%0d]: got %h exp a5a5a5a5", i, rdata0); end
      end
      if (e_v1) begin
        checks++; if (rdata1 !== 32'h12345678) begin errors++;
          $display("FAIL b2b_rdata1[%0d]: got %h exp 12345678", i, rdata1); end
      end
      tick();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_drain_bist;
    logic [AWIDTH-1:0] a_exp;
    logic [DWIDTH-1:0] d_exp;
    req0 = 1; wr0 = 0; addr0 = 4'd3;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++;
      $display("FAIL drain_gnt_c: got %b exp 1", gnt0); end
    tick();
    req0 = 0; Test = 1;
    req1 = 1; wr1 = 0; addr1 = 4'd7;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || re !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL drain_c1: got gnt=%b%b re=%b busy=%b exp 00 1 0", gnt0, gnt1, re, busy); end
    tick();
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5 || busy !== 1'b1 || bist_go !== 1'b0 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL drain_c2: got rvalid0=%b rdata0=%h busy=%b bist_go=%b gnt1=%b exp 1 a5a5a5a5 1 0 0", rvalid0, rdata0, busy, bist_go, gnt1); end
    tick();
    #1;
    checks++; if (bist_go !== 1'b0 || rvalid0 !== 1'b0 || dbg_state !== 2'd1) begin errors++;
      $display("FAIL drain_c3: got bist_go=%b rvalid0=%b state=%0d exp 0 0 1", bist_go, rvalid0, dbg_state); end
    tick();
    #1;
    checks++; if (bist_go !== 1'b1 || busy !== 1'b1 || gnt1 !== 1'b0 || dbg_state !== 2'd2) begin errors++;
      $display("FAIL drain_test_entry: got bist_go=%b busy=%b gnt1=%b state=%0d exp 1 1 0 2", bist_go, busy, gnt1, dbg_state); end

    // BIST write pass: one cycle of added latency on the ports
    for (int a = 0; a < 4; a++) begin
      bist_we = 1; bist_wraddr = 4'(8 + a); bist_datain = 32'hC0DE0000 | 32'(a);
      if (a == 0) begin
        #1;
        checks++; if (we !== 1'b0) begin errors++;
          $display("FAIL bist_we_latency: got %b exp 0", we); end
      end
      tick();
      a_exp = 4'(8 + a);
      d_exp = 32'hC0DE0000 | 32'(a);
      #1;
      checks++; if (we !== 1'b1 || wraddr !== a_exp || datain !== d_exp) begin errors++;
        $display("FAIL bist_wr[%0d]: got we=%b wraddr=%h datain=%h exp 1 %h %h", a, we, wraddr, datain, a_exp, d_exp); end
    end
    bist_we = 0;
    // BIST read pass, checking the memory contents it returns
    for (int a = 0; a < 4; a++) begin
      bist_re = 1; bist_rdaddr = 4'(8 + a);
      tick();
      a_exp = 4'(8 + a);
      #1;
      checks++; if (re !== 1'b1 || rdaddr !== a_exp || we !== 1'b0) begin errors++;
        $display("FAIL bist_rd[%0d]: got re=%b rdaddr=%h we=%b exp 1 %h 0", a, re, rdaddr, we, a_exp); end
      if (a > 0) begin
        d_exp = 32'hC0DE0000 | 32'(a - 1);
        checks++; if (mem_rdata !== d_exp) begin errors++;
          $display("FAIL bist_data[%0d]: got %h exp %h", a - 1, mem_rdata, d_exp); end
      end
    end
    bist_re = 0;
    tick();
    #1;
    checks++; if (mem_rdata !== 32'hC0DE0003 || re !== 1'b0) begin errors++;
      $display("FAIL bist_data_last: got %h re=%b exp c0de0003 0", mem_rdata, re); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'd0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL bist_quiet: got rvalid=%b%b rdata0=%h gnt=%b%b exp 00 0 00", rvalid0, rvalid1, rdata0, gnt0, gnt1); end
  endtask

  // -------------------------------------------------------------------------
  // req1 (read 7) is still pending from the drain test; requester 0 was
  // granted last, so requester 1 must win the first FUNC cycle.
  task automatic test_release;
    Test = 0;
    bist_we = 1; bist_re = 1;
    req0 = 1; wr0 = 0; addr0 = 4'd3;
    #1;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || bist_go !== 1'b1) begin errors++;
      $display("FAIL rel_exit_cycle: got gnt=%b%b bist_go=%b exp 00 1", gnt0, gnt1, bist_go); end
    tick();
    bist_we = 0; bist_re = 0;
    #1;
    checks++; if (busy !== 1'b1 || bist_go !== 1'b0 || we !== 1'b0 || re !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL rel_cycle: got busy=%b bist_go=%b we=%b re=%b gnt=%b%b exp 1 0 0 0 00", busy, bist_go, we, re, gnt0, gnt1); end
    tick();
    #1;
    checks++; if (busy !== 1'b0 || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++;
      $display("FAIL rel_func_first: got busy=%b gnt=%b%b exp 0 01", busy, gnt0, gnt1); end
    tick();
    req1 = 0;
    #1;
    checks++; if (gnt0 !== 1'b1 || re !== 1'b1 || rdaddr !== 4'd7) begin errors++;
      $display("FAIL rel_func_second: got gnt0=%b re=%b rdaddr=%h exp 1 1 7", gnt0, re, rdaddr); end
    tick();
    req0 = 0;
    #1;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678 || rvalid0 !== 1'b0) begin errors++;
      $display("FAIL rel_resp1: got rvalid1=%b rdata1=%h rvalid0=%b exp 1 12345678 0", rvalid1, rdata1, rvalid0); end
    tick();
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL rel_resp0: got rvalid0=%b rdata0=%h exp 1 a5a5a5a5", rvalid0, rdata0); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid;
    int waited;
    // mid-read
    req0 = 1; wr0 = 0; addr0 = 4'd3;
    tick();
    req0 = 0;
    req1 = 1; wr1 = 1;
    rst = 1;
    #1;
    checks++; if (re !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid_read: got re=%b gnt1=%b rvalid0=%b busy=%b exp 0 0 0 0", re, gnt1, rvalid0, busy); end
    tick();
    rst = 0; req1 = 0; wr1 = 0;
    #1;
    checks++; if (rvalid0 !== 1'b0 || we !== 1'b0) begin errors++;
      $display("FAIL rst_no_rvalid_a: got rvalid0=%b we=%b exp 0 0", rvalid0, we); end
    tick();
    #1;
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++;
      $display("FAIL rst_no_rvalid_b: got %b%b exp 00", rvalid0, rvalid1); end

    // mid-TEST
    Test = 1;
    waited = 0;
    while (!bist_go && waited < 8) begin
      tick();
      waited++;
    end
    checks++; if (bist_go !== 1'b1 || waited !== 2) begin errors++;
      $display("FAIL rst_enter_test: got bist_go=%b after %0d cycles exp 1 after 2", bist_go, waited); end
    bist_we = 1; bist_wraddr = 4'd2; bist_datain = 32'h5555AAAA;
    tick();
    #1;
    checks++; if (we !== 1'b1 || wraddr !== 4'd2) begin errors++;
      $display("FAIL rst_test_we: got we=%b wraddr=%h exp 1 2", we, wraddr); end
    rst = 1;
    #1;
    checks++; if (we !== 1'b0 || wraddr !== 4'd0 || datain !== 32'd0 || bist_go !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid_test: got we=%b wraddr=%h datain=%h bist_go=%b busy=%b exp 0 0 0 0 0", we, wraddr, datain, bist_go, busy); end
    Test = 0; bist_we = 0;
    tick();
    rst = 0;
    // pointer must be back at requester 0 even though 0 was granted last
    req0 = 1; wr0 = 1; addr0 = 4'd1;
    req1 = 1; wr1 = 1; addr1 = 4'd2;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++;
      $display("FAIL rst_ptr: got gnt=%b%b exp 10", gnt0, gnt1); end
    tick();
    idle_inputs();
    tick();
  endtask

`ifdef MBIST_ARB_STATS_EN
  task automatic test_stats;
    rst = 1;
    tick();
    rst = 0;
    req0 = 1; wr0 = 1; addr0 = 4'd1; wdata0 = 32'h1;
    for (int i = 0; i < 5; i++) tick();
    req0 = 0;
    #1;
    checks++; if (gnt_cnt0 !== 16'd5 || gnt_cnt1 !== 16'd0) begin errors++;
      $display("FAIL stats_count: got %0d %0d exp 5 0", gnt_cnt0, gnt_cnt1); end
    rst = 1;
    #1;
    checks++; if (gnt_cnt0 !== 16'd0) begin errors++;
      $display("FAIL stats_clear: got %0d exp 0", gnt_cnt0); end
    tick();
    rst = 0;
    tick();
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_drain_bist();
    test_release();
    test_reset_mid();
`ifdef MBIST_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
